// File: rtl/dm_access_unit_if.sv
// Pipeline-side and data-memory-side signals of the load/store access unit.
// The unit uses the slave modport; the driver of ops and memory data uses master.
interface dm_access_unit_if;
  logic [2:0]  is_load;
  logic [1:0]  is_store;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] dm_do;
  logic        dm_ceb;
  logic [3:0]  dm_web;
  logic [13:0] dm_addr;
  logic [31:0] dm_di;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_err;

  modport master (
    output is_load, is_store, addr, store_data, dm_do,
    input  dm_ceb, dm_web, dm_addr, dm_di, stall, load_data, load_valid, misalign_err
  );

  modport slave (
    input  is_load, is_store, addr, store_data, dm_do,
    output dm_ceb, dm_web, dm_addr, dm_di, stall, load_data, load_valid, misalign_err
  );
endinterface

// File: rtl/dm_access_unit.sv
// Single-outstanding load/store unit: captures an op, drives the data memory
// for one store cycle or MEM_LAT load cycles, then reports in a one-cycle RESP.
module dm_access_unit #(
  parameter int MEM_LAT = 1
) (
  input logic            clk,
  input logic            rst,
  dm_access_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic [2:0]  ld_q;
  logic [1:0]  st_q;
  logic [31:0] addr_q, di_q, load_data_q;
  logic        mis_q;
  logic [2:0]  cnt;

  logic        op, mis_in;
  logic [31:0] di_in, ext;
  logic [3:0]  web_st;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  logic        stall, ceb, load_valid, misalign_err;
  logic [3:0]  web;

  assign op = (bus.is_load != 3'd0) || (bus.is_store != 2'd0);

  // A present store always wins, so the load's alignment is irrelevant then.
  always_comb begin
    mis_in = 1'b0;
    if (bus.is_store != 2'd0) begin
      case (bus.is_store)
        2'b01:   mis_in = bus.addr[1:0] != 2'b00;
        2'b10:   mis_in = bus.addr[0];
        default: mis_in = 1'b0;
      endcase
    end else begin
      case (bus.is_load)
        3'b011:        mis_in = bus.addr[1:0] != 2'b00;
        3'b010, 3'b100: mis_in = bus.addr[0];
        default:       mis_in = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (bus.is_store)
      2'b10:   di_in = {2{bus.store_data[15:0]}};
      2'b11:   di_in = {4{bus.store_data[7:0]}};
      default: di_in = bus.store_data;
    endcase
  end

  always_comb begin
    case (st_q)
      2'b01:   web_st = 4'b0000;
      2'b10:   web_st = addr_q[1] ? 4'b0011 : 4'b1100;
      2'b11:   web_st = ~(4'b0001 << addr_q[1:0]);
      default: web_st = 4'b1111;
    endcase
  end

  always_comb begin
    byte_sel = 8'(bus.dm_do >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? bus.dm_do[31:16] : bus.dm_do[15:0];
    case (ld_q)
      3'b001:  ext = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  ext = {16'h0000, half_sel};
      3'b101:  ext = {24'h000000, byte_sel};
      default: ext = bus.dm_do;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    ceb          = 1'b1;
    web          = 4'hF;
    load_valid   = 1'b0;
    misalign_err = 1'b0;
    case (state)
      IDLE: begin
        stall = op;
        if (op) state_nxt = mis_in ? RESP : ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        ceb   = 1'b0;
        if (st_q != 2'd0) begin
          web       = web_st;
          state_nxt = RESP;
        end else if (cnt == LAST) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        load_valid   = (ld_q != 3'd0) && !mis_q;
        misalign_err = mis_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q        <= 3'd0;
      st_q        <= 2'd0;
      addr_q      <= 32'd0;
      di_q        <= 32'd0;
      mis_q       <= 1'b0;
      cnt         <= 3'd0;
      load_data_q <= 32'd0;
    end else begin
      case (state)
        IDLE: if (op) begin
          st_q   <= bus.is_store;
          ld_q   <= (bus.is_store != 2'd0) ? 3'd0 : bus.is_load;
          addr_q <= bus.addr;
          di_q   <= di_in;
          mis_q  <= mis_in;
          cnt    <= 3'd0;
          if (mis_in) load_data_q <= 32'd0;
        end
        ACCESS: if (st_q == 2'd0) begin
          if (cnt == LAST) load_data_q <= ext;
          else             cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall        = stall;
  assign bus.dm_ceb       = ceb;
  assign bus.dm_web       = web;
  assign bus.dm_addr      = addr_q[15:2];
  assign bus.dm_di        = di_q;
  assign bus.load_data    = load_data_q;
  assign bus.load_valid   = load_valid;
  assign bus.misalign_err = misalign_err;
endmodule

// File: tb/tb_dm_access_unit.sv
// Directed vector bench for dm_access_unit with MEM_LAT=3, plus a mid-access reset sequence.
module tb_dm_access_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  dm_access_unit_if bus ();

  dm_access_unit #(.MEM_LAT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] dout;
    int          e_resp;
    int          e_ceb;
    logic [3:0]  e_web;
    logic [13:0] e_daddr;
    logic [31:0] e_di;
    logic        e_lv;
    logic        e_err;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.is_load    = v.ld;
    bus.is_store   = v.st;
    bus.addr       = v.addr;
    bus.store_data = v.sdata;
    bus.dm_do      = v.dout;
  endtask

  task automatic clear_op();
    bus.is_load  = 3'd0;
    bus.is_store = 2'd0;
  endtask

  // Presents one op, samples every cycle until the non-stalling RESP cycle.
  task automatic run_vec(input vec_t v, input bit sync, input int idx);
    int          k = 0;
    int          ceb_n = 0;
    bit          done = 0;
    bit          early = 0;
    bit          idle_web_bad = 0;
    logic [3:0]  web_acc = 4'hF;
    logic        lv = 1'b0, err = 1'b0;
    logic [31:0] ld = 32'd0, di = 32'd0;
    logic [13:0] da = 14'd0;
    if (sync) @(negedge clk);
    drive(v);
    #1;
    while (!done && k < 20) begin
      if (!bus.dm_ceb) begin
        ceb_n++;
        web_acc &= bus.dm_web;
      end else if (bus.dm_web !== 4'hF) begin
        idle_web_bad = 1;
      end
      if (!bus.stall) begin
        done = 1;
        lv  = bus.load_valid;
        err = bus.misalign_err;
        ld  = bus.load_data;
        di  = bus.dm_di;
        da  = bus.dm_addr;
      end else begin
        if (bus.load_valid || bus.misalign_err) early = 1;
        k++;
        @(negedge clk);
      end
    end
    clear_op();
    chk($sformatf("v%0d_timeout", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d_resp_cycle", idx), k, v.e_resp);
    chk($sformatf("v%0d_ceb_cycles", idx), ceb_n, v.e_ceb);
    chk($sformatf("v%0d_web", idx), 32'(web_acc), 32'(v.e_web));
    chk($sformatf("v%0d_idle_web", idx), 32'(idle_web_bad), 32'd0);
    chk($sformatf("v%0d_early_pulse", idx), 32'(early), 32'd0);
    chk($sformatf("v%0d_dm_addr", idx), 32'(da), 32'(v.e_daddr));
    if (v.st != 2'd0) chk($sformatf("v%0d_dm_di", idx), di, v.e_di);
    chk($sformatf("v%0d_load_valid", idx), 32'(lv), 32'(v.e_lv));
    chk($sformatf("v%0d_misalign_err", idx), 32'(err), 32'(v.e_err));
    chk($sformatf("v%0d_load_data", idx), ld, v.e_ld);
  endtask

  initial begin
    vec_t lw;
    //            ld      st     addr          sdata         dout        rsp ceb web      daddr     di           lv    err   load_data
    vecs[0]  = '{3'b000, 2'b01, 32'h0000_0104, 32'hDEADBEEF, 32'h0,       2, 1, 4'b0000, 14'h041, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{3'b000, 2'b11, 32'h0000_0107, 32'h0000_00A5, 32'h0,      2, 1, 4'b0111, 14'h041, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{3'b000, 2'b10, 32'h0000_0106, 32'h1234_BEEF, 32'h0,      2, 1, 4'b0011, 14'h041, 32'hBEEFBEEF, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{3'b000, 2'b10, 32'h0000_0200, 32'h0000_CAFE, 32'h0,      2, 1, 4'b1100, 14'h080, 32'hCAFECAFE, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{3'b001, 2'b00, 32'h0000_0202, 32'h0,  32'h0080_0000,     4, 3, 4'b1111, 14'h080, 32'h0,        1'b1, 1'b0, 32'hFFFF_FF80};
    vecs[5]  = '{3'b101, 2'b00, 32'h0000_0202, 32'h0,  32'h0080_0000,     4, 3, 4'b1111, 14'h080, 32'h0,        1'b1, 1'b0, 32'h0000_0080};
    vecs[6]  = '{3'b011, 2'b00, 32'h0000_0010, 32'h0,  32'h89AB_CDEF,     4, 3, 4'b1111, 14'h004, 32'h0,        1'b1, 1'b0, 32'h89AB_CDEF};
    vecs[7]  = '{3'b010, 2'b00, 32'h0000_0002, 32'h0,  32'h8001_0000,     4, 3, 4'b1111, 14'h000, 32'h0,        1'b1, 1'b0, 32'hFFFF_8001};
    vecs[8]  = '{3'b100, 2'b00, 32'h0000_0002, 32'h0,  32'h8001_0000,     4, 3, 4'b1111, 14'h000, 32'h0,        1'b1, 1'b0, 32'h0000_8001};
    vecs[9]  = '{3'b010, 2'b00, 32'h0000_0001, 32'h0,  32'h1234_5678,     1, 0, 4'b1111, 14'h000, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[10] = '{3'b001, 2'b00, 32'h0000_0203, 32'h0,  32'h7F00_0000,     4, 3, 4'b1111, 14'h080, 32'h0,        1'b1, 1'b0, 32'h0000_007F};
    vecs[11] = '{3'b011, 2'b01, 32'h0000_0010, 32'h0000_0055, 32'h0,      2, 1, 4'b0000, 14'h004, 32'h0000_0055, 1'b0, 1'b0, 32'h0000_007F};
    vecs[12] = '{3'b000, 2'b01, 32'h0000_0102, 32'h0000_0001, 32'h0,      1, 0, 4'b1111, 14'h040, 32'h0000_0001, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{3'b000, 2'b11, 32'h0000_0010, 32'h0000_001C, 32'h0,      2, 1, 4'b1110, 14'h004, 32'h1C1C1C1C, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{3'b100, 2'b00, 32'h0001_FFFE, 32'h0,  32'hFEDC_1234,     4, 3, 4'b1111, 14'h3FFF, 32'h0,       1'b1, 1'b0, 32'h0000_FEDC};
    vecs[15] = '{3'b011, 2'b00, 32'h0000_0003, 32'h0,  32'h1111_1111,     1, 0, 4'b1111, 14'h000, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[16] = '{3'b001, 2'b00, 32'h0000_0000, 32'h0,  32'h0000_00FF,     4, 3, 4'b1111, 14'h000, 32'h0,        1'b1, 1'b0, 32'hFFFF_FFFF};
    lw       = '{3'b011, 2'b00, 32'h0000_0020, 32'h0,  32'h1122_3344,     4, 3, 4'b1111, 14'h008, 32'h0,        1'b1, 1'b0, 32'h1122_3344};

    rst = 1'b1;
    bus.is_load = 3'd0; bus.is_store = 2'd0; bus.addr = 32'd0;
    bus.store_data = 32'd0; bus.dm_do = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_ceb", 32'(bus.dm_ceb), 32'd1);
    chk("rst_web", 32'(bus.dm_web), 32'hF);
    chk("rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("rst_dm_di", bus.dm_di, 32'd0);
    chk("rst_load_data", bus.load_data, 32'd0);
    chk("rst_load_valid", 32'(bus.load_valid), 32'd0);
    chk("rst_misalign_err", 32'(bus.misalign_err), 32'd0);
    chk("rst_stall_no_op", 32'(bus.stall), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) run_vec(vecs[i], 1'b1, i);

    // Reset during the second ACCESS cycle of an LW, then re-execution.
    @(negedge clk);
    drive(lw);
    #1 chk("mid_cap_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk("mid_acc1_ceb", 32'(bus.dm_ceb), 32'd0);
    @(negedge clk);
    chk("mid_acc2_ceb", 32'(bus.dm_ceb), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_ceb", 32'(bus.dm_ceb), 32'd1);
    chk("mid_rst_web", 32'(bus.dm_web), 32'hF);
    chk("mid_rst_dm_addr", 32'(bus.dm_addr), 32'd0);
    chk("mid_rst_dm_di", bus.dm_di, 32'd0);
    chk("mid_rst_load_data", bus.load_data, 32'd0);
    chk("mid_rst_load_valid", 32'(bus.load_valid), 32'd0);
    chk("mid_rst_misalign_err", 32'(bus.misalign_err), 32'd0);
    chk("mid_rst_stall_op", 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk("mid_rst_hold_load_valid", 32'(bus.load_valid), 32'd0);
    chk("mid_rst_hold_ceb", 32'(bus.dm_ceb), 32'd1);
    rst = 1'b0;
    run_vec(lw, 1'b0, 100);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
